fifo_sync_param: RTL and testbench

//  Parametrised single-clock synchronous FIFO; successor to the fixed 8x8 FIFO.

---
 rtl/fifo_sync_param.sv | 97 +++++++++
 tb/tb_fifo_sync_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with almost-full/empty thresholds, optional
// first-word-fall-through read data, sticky error flags and a drop counter.
module fifo_sync_param #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_WIDTH = 8,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic                          fifo_write,
  input  logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_read,
  output logic [FIFO_WIDTH-1:0]         fifo_data_out,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          fifo_almost_full,
  output logic                          fifo_almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  input  logic                          clr_err,
  output logic                          fifo_overflow,
  output logic                          fifo_underflow,
  output logic [7:0]                    fifo_drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  rd_acc, wr_acc, ovf_set, unf_set;

  assign fifo_cnt          = cnt;
  assign fifo_full         = (cnt == CW'(FIFO_DEPTH));
  assign fifo_empty        = (cnt == '0);
  assign fifo_almost_full  = (cnt >= CW'(AF_THRESH));
  assign fifo_almost_empty = (cnt <= CW'(AE_THRESH));

  // A read frees a slot in the same cycle, so a full FIFO still takes a write.
  assign rd_acc  = fifo_read & ~fifo_empty;
  assign wr_acc  = fifo_write & (~fifo_full | rd_acc);
  assign ovf_set = fifo_write & ~wr_acc;
  assign unf_set = fifo_read & fifo_empty;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= fifo_data_in;
  end

  // Sticky errors: a new rejection outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
      fifo_drop_cnt  <= 8'd0;
    end else begin
      fifo_overflow  <= ovf_set | (fifo_overflow  & ~clr_err);
      fifo_underflow <= unf_set | (fifo_underflow & ~clr_err);
      if (ovf_set) begin
        if (clr_err)                     fifo_drop_cnt <= 8'd1;
        else if (fifo_drop_cnt != 8'hFF) fifo_drop_cnt <= fifo_drop_cnt + 8'd1;
      end else if (clr_err) begin
        fifo_drop_cnt <= 8'd0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign fifo_data_out = mem[rd_ptr];
    end else begin : g_reg
      always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)       fifo_data_out <= '0;
        else if (rd_acc) fifo_data_out <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Two FIFO configurations (8x8 registered, 16x32 FWFT) checked every cycle
// against queue models, with directed scenarios and randomized traffic.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_;

  logic        w0 = 0, r0 = 0, c0 = 0;
  logic [7:0]  d0 = 0, q0, dc0;
  logic        f0, e0, af0, ae0, ov0, un0;
  logic [3:0]  cnt0;

  logic        w1 = 0, r1 = 0, c1 = 0;
  logic [31:0] d1 = 0, q1;
  logic [7:0]  dc1;
  logic        f1, e1, af1, ae1, ov1, un1;
  logic [4:0]  cnt1;

  fifo_sync_param u0 (
    .clk(clk), .rst_(rst_), .fifo_write(w0), .fifo_data_in(d0), .fifo_read(r0),
    .fifo_data_out(q0), .fifo_full(f0), .fifo_empty(e0), .fifo_almost_full(af0),
    .fifo_almost_empty(ae0), .fifo_cnt(cnt0), .clr_err(c0), .fifo_overflow(ov0),
    .fifo_underflow(un0), .fifo_drop_cnt(dc0));

  fifo_sync_param #(.FIFO_DEPTH(16), .FIFO_WIDTH(32), .AF_THRESH(12), .AE_THRESH(3), .FWFT(1)) u1 (
    .clk(clk), .rst_(rst_), .fifo_write(w1), .fifo_data_in(d1), .fifo_read(r1),
    .fifo_data_out(q1), .fifo_full(f1), .fifo_empty(e1), .fifo_almost_full(af1),
    .fifo_almost_empty(ae1), .fifo_cnt(cnt1), .clr_err(c1), .fifo_overflow(ov1),
    .fifo_underflow(un1), .fifo_drop_cnt(dc1));

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Models: occupancy is the queue length; errors follow the accept rules.
  logic [7:0]  mq0[$];
  logic [31:0] mq1[$];
  bit          mov0 = 0, mun0 = 0, mov1 = 0, mun1 = 0;
  int          mdc0 = 0, mdc1 = 0;
  logic [7:0]  mdo0 = 0;
  bit          ra0, wa0, os0, us0, ra1, wa1, os1, us1;

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mq0.delete(); mov0 = 0; mun0 = 0; mdc0 = 0; mdo0 = 0;
    end else begin
      ra0 = r0 && mq0.size() > 0;
      wa0 = w0 && (mq0.size() < 8 || ra0);
      os0 = w0 && !wa0;
      us0 = r0 && mq0.size() == 0;
      if (ra0) mdo0 = mq0.pop_front();
      if (wa0) mq0.push_back(d0);
      mov0 = os0 || (mov0 && !c0);
      mun0 = us0 || (mun0 && !c0);
      if (os0) mdc0 = c0 ? 1 : (mdc0 < 255 ? mdc0 + 1 : 255);
      else if (c0) mdc0 = 0;
    end
  end

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mq1.delete(); mov1 = 0; mun1 = 0; mdc1 = 0;
    end else begin
      ra1 = r1 && mq1.size() > 0;
      wa1 = w1 && (mq1.size() < 16 || ra1);
      os1 = w1 && !wa1;
      us1 = r1 && mq1.size() == 0;
      if (ra1) void'(mq1.pop_front());
      if (wa1) mq1.push_back(d1);
      mov1 = os1 || (mov1 && !c1);
      mun1 = us1 || (mun1 && !c1);
      if (os1) mdc1 = c1 ? 1 : (mdc1 < 255 ? mdc1 + 1 : 255);
      else if (c1) mdc1 = 0;
    end
  end

  always @(negedge clk) begin
    chk("u0.cnt",   32'(cnt0), 32'(mq0.size()));
    chk("u0.full",  32'(f0),   32'(mq0.size() == 8));
    chk("u0.empty", 32'(e0),   32'(mq0.size() == 0));
    chk("u0.af",    32'(af0),  32'(mq0.size() >= 6));
    chk("u0.ae",    32'(ae0),  32'(mq0.size() <= 2));
    chk("u0.ovf",   32'(ov0),  32'(mov0));
    chk("u0.unf",   32'(un0),  32'(mun0));
    chk("u0.drop",  32'(dc0),  32'(mdc0));
    chk("u0.dout",  32'(q0),   32'(mdo0));
    chk("u1.cnt",   32'(cnt1), 32'(mq1.size()));
    chk("u1.full",  32'(f1),   32'(mq1.size() == 16));
    chk("u1.empty", 32'(e1),   32'(mq1.size() == 0));
    chk("u1.af",    32'(af1),  32'(mq1.size() >= 12));
    chk("u1.ae",    32'(ae1),  32'(mq1.size() <= 3));
    chk("u1.ovf",   32'(ov1),  32'(mov1));
    chk("u1.unf",   32'(un1),  32'(mun1));
    chk("u1.drop",  32'(dc1),  32'(mdc1));
    if (mq1.size() > 0) chk("u1.dout", q1, mq1[0]);
  end

  task automatic tick();
    @(posedge clk); #1;
    w0 = 0; r0 = 0; c0 = 0; w1 = 0; r1 = 0; c1 = 0;
  endtask

  initial begin
    rst_ = 1'b1;
    #1 rst_ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.empty", 32'(e0), 1);
    chk("rst.dout",  32'(q0), 0);
    rst_ = 1'b1;

    // Reset in the middle of a stream.
    for (int i = 1; i <= 3; i++) begin w0 = 1; d0 = 8'(i); tick(); end
    #2 rst_ = 1'b0;
    #1;
    chk("midrst.cnt",  32'(cnt0), 0);
    chk("midrst.empty", 32'(e0), 1);
    chk("midrst.full",  32'(f0), 0);
    chk("midrst.ae",    32'(ae0), 1);
    chk("midrst.ovf",   32'(ov0 | un0), 0);
    @(posedge clk); #1 rst_ = 1'b1;

    // Fill and drain in order.
    for (int i = 1; i <= 8; i++) begin
      w0 = 1; d0 = 8'(i); tick();
      if (i == 5) chk("fill.af5", 32'(af0), 0);
      if (i == 6) chk("fill.af6", 32'(af0), 1);
      if (i == 7) chk("fill.full7", 32'(f0), 0);
    end
    chk("fill.full8", 32'(f0), 1);
    chk("fill.cnt8", 32'(cnt0), 8);
    for (int i = 1; i <= 8; i++) begin
      r0 = 1; tick();
      chk("drain.data", 32'(q0), 32'(i));
    end
    chk("drain.empty", 32'(e0), 1);

    // Rejected writes while full, then write+read while full.
    for (int i = 1; i <= 8; i++) begin w0 = 1; d0 = 8'(i); tick(); end
    for (int k = 0; k < 3; k++) begin w0 = 1; d0 = 8'hAA; tick(); end
    chk("ovf.drop3", 32'(dc0), 3);
    chk("ovf.flag", 32'(ov0), 1);
    chk("ovf.cnt", 32'(cnt0), 8);
    w0 = 1; d0 = 8'h55; r0 = 1; tick();
    chk("wr_rd_full.cnt", 32'(cnt0), 8);
    chk("wr_rd_full.data", 32'(q0), 1);
    for (int i = 2; i <= 9; i++) begin
      r0 = 1; tick();
      chk("post_ovf.data", 32'(q0), (i == 9) ? 32'h55 : 32'(i));
    end

    // Underflow with simultaneous write, then clear.
    r0 = 1; w0 = 1; d0 = 8'h33; tick();
    chk("unf.flag", 32'(un0), 1);
    chk("unf.cnt", 32'(cnt0), 1);
    c0 = 1; tick();
    chk("clr.unf", 32'(un0), 0);
    chk("clr.ovf", 32'(ov0), 0);
    chk("clr.drop", 32'(dc0), 0);
    r0 = 1; tick();
    chk("unf.data", 32'(q0), 32'h33);

    // Clear colliding with a rejection, then drop counter saturation.
    for (int i = 1; i <= 8; i++) begin w0 = 1; d0 = 8'(i); tick(); end
    w0 = 1; c0 = 1; tick();
    chk("clrset.drop", 32'(dc0), 1);
    chk("clrset.ovf", 32'(ov0), 1);
    repeat (260) begin w0 = 1; d0 = 8'hEE; tick(); end
    chk("sat.drop", 32'(dc0), 255);
    repeat (8) begin r0 = 1; tick(); end

    // FWFT: word visible one cycle after write, then wrap-around traffic.
    w1 = 1; d1 = 32'hDEADBEEF; tick();
    chk("fwft.data", q1, 32'hDEADBEEF);
    chk("fwft.empty", 32'(e1), 0);
    r1 = 1; tick();
    for (int i = 0; i < 20; i++) begin
      w1 = 1; d1 = 32'h1000 + 32'(i); r1 = (i > 0); tick();
      chk("fwft.wrap", q1, 32'h1000 + 32'(i));
    end
    r1 = 1; tick();

    // Randomized traffic with alternating fill/drain bias.
    for (int i = 0; i < 3000; i++) begin
      bit fillp;
      fillp = ((i / 150) % 2) == 0;
      w0 = ($urandom_range(0, 3) < (fillp ? 3 : 1));
      r0 = ($urandom_range(0, 3) < (fillp ? 1 : 3));
      d0 = 8'($urandom);
      c0 = ($urandom_range(0, 31) == 0);
      w1 = ($urandom_range(0, 3) < (fillp ? 3 : 1));
      r1 = ($urandom_range(0, 3) < (fillp ? 1 : 3));
      d1 = $urandom;
      c1 = ($urandom_range(0, 31) == 0);
      if (i == 1500) begin
        #2 rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
